// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: data/instr requesters plus the memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_data;
    logic              we_data;
    logic [ADDR_W-1:0] addr_data;
    logic [DATA_W-1:0] wdata_data;
    logic [DATA_W-1:0] rdata_data;
    logic              ready_data;
    logic              err_data;

    logic              req_instr;
    logic              we_instr;
    logic [ADDR_W-1:0] addr_instr;
    logic [DATA_W-1:0] wdata_instr;
    logic [DATA_W-1:0] rdata_instr;
    logic              ready_instr;
    logic              err_instr;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req_data, we_data, addr_data, wdata_data,
        output rdata_data, ready_data, err_data,
        input  req_instr, we_instr, addr_instr, wdata_instr,
        output rdata_instr, ready_instr, err_instr,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output req_data, we_data, addr_data, wdata_data,
        input  rdata_data, ready_data, err_data,
        output req_instr, we_instr, addr_instr, wdata_instr,
        input  rdata_instr, ready_instr, err_instr,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data/instr arbiter for the single memory port, with timeout watchdog.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ABORT
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              gnt_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_data_q;
    logic [DATA_W-1:0] rdata_instr_q;
    logic              ready_data_q;
    logic              ready_instr_q;
    logic              err_data_q;
    logic              err_instr_q;

    logic              any_req;
    logic              gnt_d;
    logic              we_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_q;

    always_comb begin
        any_req = bus.req_data | bus.req_instr;
        if (bus.req_data && bus.req_instr) gnt_d = ~last_q;
        else                               gnt_d = bus.req_data;
        we_d = gnt_d ? bus.we_data : bus.we_instr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                          last_q <= 1'b0;
        else if (state_q == IDLE && any_req) last_q <= gnt_d;
    end
`else
    always_comb begin
        any_req = bus.req_data | bus.req_instr;
        gnt_d   = bus.req_data;
        we_d    = gnt_d ? bus.we_data : bus.we_instr;
    end
`endif

    // gnt_q = 1 means the data side owns the transfer in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gnt_q         <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_data_q  <= '0;
            rdata_instr_q <= '0;
            ready_data_q  <= 1'b0;
            ready_instr_q <= 1'b0;
            err_data_q    <= 1'b0;
            err_instr_q   <= 1'b0;
        end else begin
            ready_data_q  <= 1'b0;
            ready_instr_q <= 1'b0;
            err_data_q    <= 1'b0;
            err_instr_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q       <= gnt_d;
                        mem_read_q  <= ~we_d;
                        mem_write_q <= we_d;
                        mem_addr_q  <= gnt_d ? bus.addr_data : bus.addr_instr;
                        mem_wdata_q <= gnt_d ? bus.wdata_data : bus.wdata_instr;
                        cnt_q       <= '0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (bus.mem_ready) begin
                        if (mem_read_q) begin
                            if (gnt_q) rdata_data_q  <= bus.mem_rdata;
                            else       rdata_instr_q <= bus.mem_rdata;
                        end
                        ready_data_q  <= gnt_q;
                        ready_instr_q <= ~gnt_q;
                        mem_read_q    <= 1'b0;
                        mem_write_q   <= 1'b0;
                        state_q       <= RESP;
                    end else if (cnt_q == LAST) begin
                        err_data_q  <= gnt_q;
                        err_instr_q <= ~gnt_q;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ABORT;
                    end
                end
                RESP:  state_q <= IDLE;
                ABORT: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.rdata_data  = rdata_data_q;
    assign bus.rdata_instr = rdata_instr_q;
    assign bus.ready_data  = ready_data_q;
    assign bus.ready_instr = ready_instr_q;
    assign bus.err_data    = err_data_q;
    assign bus.err_instr   = err_instr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
    );

    typedef struct {
        logic [3:0]  pulse;
        logic [31:0] rd_d;
        logic [31:0] rd_i;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rdd = '0;
    logic [31:0] exp_rdi = '0;
    int          passed = 0;
    int          total  = 0;

    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_val = '0;

    // Memory model: mem_ready after mem_lat strobe cycles, 0 = never
    always @(negedge clk) begin
        if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
            mem_cnt++;
            bus.mem_ready = (mem_lat != 0 && mem_cnt == mem_lat);
        end else begin
            mem_cnt = 0;
            bus.mem_ready = 1'b0;
        end
        bus.mem_rdata = mem_val;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_tx(input bit side_d, input bit is_err,
                             input bit is_rd, input logic [31:0] v);
        exp_t e;
        if (!is_err && is_rd) begin
            if (side_d) exp_rdd = v;
            else        exp_rdi = v;
        end
        e.pulse = {side_d & !is_err, !side_d & !is_err,
                   side_d & is_err, !side_d & is_err};
        e.rd_d = exp_rdd;
        e.rd_i = exp_rdi;
        sb.push_back(e);
    endtask

    task automatic check_pulse(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(tag,
                {bus.ready_data, bus.ready_instr, bus.err_data,
                 bus.err_instr, bus.rdata_data, bus.rdata_instr},
                {e.pulse, e.rd_d, e.rd_i});
        end
    endtask

    task automatic wait_pulse(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.ready_data | bus.ready_instr |
                bus.err_data | bus.err_instr) begin
                seen = 1'b1;
                check_pulse(tag);
            end
        end
        chk({tag, "_arrived"}, 128'(seen), 128'(1));
    endtask

    task automatic drive(input bit side_d, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (side_d) begin
            bus.req_data = 1'b1; bus.we_data = we;
            bus.addr_data = a;   bus.wdata_data = wd;
        end else begin
            bus.req_instr = 1'b1; bus.we_instr = we;
            bus.addr_instr = a;   bus.wdata_instr = wd;
        end
    endtask

    initial begin
        int n;
        bus.req_data = 0;  bus.we_data = 0;
        bus.addr_data = 0; bus.wdata_data = 0;
        bus.req_instr = 0;  bus.we_instr = 0;
        bus.addr_instr = 0; bus.wdata_instr = 0;
        bus.mem_ready = 0;  bus.mem_rdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctl",
            {bus.ready_data, bus.err_data, bus.ready_instr, bus.err_instr,
             bus.mem_read, bus.mem_write, busy}, '0);
        chk("reset_data",
            {bus.rdata_data, bus.rdata_instr, bus.mem_addr}, '0);
        chk("reset_wdata", bus.mem_wdata, '0);
        rst_n = 1'b1;

        // Data-side read, memory answers 2 cycles after mem_read rises
        @(negedge clk);
        mem_lat = 2; mem_val = 32'hDEADBEEF;
        expect_tx(1, 0, 1, mem_val);
        drive(1, 0, 32'h100, 32'h0);
        @(negedge clk);
        chk("rd_cmd", {bus.mem_read, bus.mem_write, busy}, 3'b101);
        chk("rd_addr", bus.mem_addr, 32'h100);
        wait_pulse("rd_data");
        bus.req_data = 0;

        // Instr-side write
        @(negedge clk);
        mem_lat = 3;
        expect_tx(0, 0, 0, '0);
        drive(0, 1, 32'h40, 32'h12345678);
        @(negedge clk);
        chk("wr_cmd", {bus.mem_read, bus.mem_write}, 2'b01);
        chk("wr_addr", bus.mem_addr, 32'h40);
        chk("wr_wdata", bus.mem_wdata, 32'h12345678);
        @(negedge clk);
        chk("wr_hold", {bus.mem_write, bus.mem_wdata}, {1'b1, 32'h12345678});
        wait_pulse("wr_instr");
        bus.req_instr = 0;

        // Simultaneous pairs: D then I each time
        mem_lat = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_val = 32'h1000 + 32'(k);
            expect_tx(1, 0, 1, mem_val);
            expect_tx(0, 0, 1, mem_val);
            drive(1, 0, 32'h500 + 32'(k), '0);
            drive(0, 0, 32'h600 + 32'(k), '0);
            wait_pulse($sformatf("pair%0d_d", k));
            bus.req_data = 0;
            wait_pulse($sformatf("pair%0d_i", k));
            bus.req_instr = 0;
        end

        // Timeout: memory never answers
        @(negedge clk);
        mem_lat = 0;
        expect_tx(1, 1, 1, '0);
        drive(1, 0, 32'h200, '0);
        n = 0;
        @(negedge clk);
        while (bus.mem_read && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", 128'(n), 128'(8));
        chk("to_busy_abort", busy, 1'b1);
        check_pulse("to_err");
        bus.req_data = 0;
        @(negedge clk);
        chk("to_busy_idle", busy, 1'b0);

        // Timeout race: mem_ready on the final ACCESS cycle wins
        mem_lat = 8; mem_val = 32'hA5A5A5A5;
        expect_tx(1, 0, 1, mem_val);
        drive(1, 0, 32'h204, '0);
        wait_pulse("race");
        bus.req_data = 0;

        // Reset mid-access
        @(negedge clk);
        mem_lat = 0;
        drive(0, 0, 32'h300, '0);
        repeat (2) @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        bus.req_instr = 0;
        @(negedge clk);
        chk("mid_rst_ctl",
            {bus.ready_data, bus.err_data, bus.ready_instr, bus.err_instr,
             bus.mem_read, bus.mem_write, busy}, '0);
        chk("mid_rst_data",
            {bus.rdata_data, bus.rdata_instr, bus.mem_addr, bus.mem_wdata},
            '0);
        exp_rdd = '0; exp_rdi = '0;
        @(negedge clk);
        chk("mid_rst_quiet",
            {bus.ready_data, bus.err_data, bus.ready_instr, bus.err_instr},
            '0);
        rst_n = 1'b1;

        // Fresh request after reset, minimum latency
        @(negedge clk);
        mem_lat = 1; mem_val = 32'hCAFEF00D;
        expect_tx(1, 0, 1, mem_val);
        drive(1, 0, 32'h304, '0);
        @(negedge clk);
        chk("fresh_cmd", {bus.mem_read, bus.mem_addr}, {1'b1, 32'h304});
        @(negedge clk);
        check_pulse("fresh_ready");
        bus.req_data = 0;
        repeat (2) @(negedge clk);

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Clocked arbiter that shares the single main-memory port between the data-side and instruction-side requesters.
- Replaces level-sensitive steering with a registered FSM: one transfer in flight, registered memory commands, and a one-cycle ready pulse per completed transfer.
- A timeout watchdog aborts transfers the memory never acknowledges.
- Sits between the pipeline memory stages and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles waiting for mem_ready before abort (must be >= 2)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- req_data  input  1  data-side request, level, held until ready_data or err_data
- we_data  input  1  1 = write, 0 = read (data side)
- addr_data  input  ADDR_W  data-side address
- wdata_data  input  DATA_W  data-side write data
- rdata_data  output  DATA_W  data-side read data, valid while ready_data=1
- ready_data  output  1  one-cycle completion pulse (data side)
- err_data  output  1  one-cycle timeout pulse (data side)
- req_instr, we_instr, addr_instr, wdata_instr  input  1/1/ADDR_W/DATA_W  same meaning, instruction side
- rdata_instr, ready_instr, err_instr  output  DATA_W/1/1  same meaning, instruction side
- mem_read  output  1  memory read strobe, level for the whole access
- mem_write  output  1  memory write strobe, level for the whole access
- mem_addr  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched write data
- mem_rdata  input  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  input  1  memory completion, one cycle
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; timeout counter 0; last-grant register = instr. All outputs 0, including rdata_*, mem_addr and mem_wdata.
- Reset mid-access: the access is abandoned silently; no ready or err pulse is issued.
- States: IDLE, ACCESS, RESP, ABORT.
- IDLE: samples req_data and req_instr.
  - If any request is present, latch the winner's we, addr and wdata; record the grant; go to ACCESS.
  - mem_read or mem_write rises on the same edge, so the command is visible 1 cycle after req is sampled.
  - mem_ready arriving in IDLE is ignored.
- Arbitration (default): data side wins when both requests are present in the same cycle. The loser stays pending and is granted on the next IDLE.
- ACCESS:
  - mem_read = ~we, mem_write = we; mem_addr and mem_wdata held constant.
  - Counter increments each cycle.
  - On mem_ready=1: capture mem_rdata into the granted side's rdata register (reads only; rdata is left unchanged on writes). Drop the strobes and go to RESP.
  - If the counter reaches TIMEOUT-1 without mem_ready: drop the strobes and go to ABORT.
  - mem_ready arriving in that same cycle takes precedence over the timeout.
- RESP: the granted side's ready is 1 for exactly one cycle; requests are ignored; next state IDLE. A requester sampling its ready must drop req by the following edge, otherwise it is re-granted.
- ABORT: the granted side's err is 1 for one cycle; rdata is unchanged; next state IDLE.
- Throughput: minimum 3 cycles per transfer (IDLE, ACCESS, RESP) when mem_ready arrives in the first ACCESS cycle.
- Counter width is clog2(TIMEOUT); the counter clears on entry to ACCESS.
- A requester whose req drops while it is granted still receives its ready/err pulse.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, the side not recorded in last-grant wins. Last-grant updates on every grant. Single requests are granted immediately regardless of last-grant.
- Undefined: fixed data-over-instruction priority. The last-grant register is not built.

Test Plan:
- Read, data side:
  - Stimulus: reset, then req_data=1, we_data=0, addr_data=0x100; memory returns mem_ready with mem_rdata=0xDEADBEEF 2 cycles after mem_read rises.
  - Required: mem_read=1 and mem_addr=0x100 one cycle after req is sampled; ready_data=1 for one cycle with rdata_data=0xDEADBEEF; ready_instr stays 0.
- Write, instruction side:
  - Stimulus: req_instr=1, we_instr=1, addr_instr=0x40, wdata_instr=0x12345678.
  - Required: mem_write=1, mem_wdata=0x12345678 held until mem_ready; then ready_instr pulses once; rdata_instr unchanged.
- Simultaneous requests, three back-to-back pairs (both reqs re-asserted after each pulse):
  - Default build: grant order D, I, D, I, D, I (loser served next).
  - With MEM_ARB_ROUND_ROBIN_EN: first grant D (last-grant=instr after reset), then alternating.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_ready held 0.
  - Required: strobes drop after 8 ACCESS cycles; err_data pulses once; ready_data stays 0; busy drops the cycle after.
- Timeout race:
  - Stimulus: mem_ready=1 in the final ACCESS cycle.
  - Required: ready pulse, no err.
- Reset mid-access:
  - Stimulus: rst_n=0 during ACCESS.
  - Required: next cycle all outputs 0, busy=0, no ready or err pulse; a fresh req after reset is served normally.
